// File: rtl/uart_hex_pkg.sv
// Shared constants, bit-FSM state encoding and ASCII hex decoding for the
// hex-line UART receiver.
package uart_hex_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } bit_state_t;

    // Returns {valid, nibble}; nibble is zero when the character is not hex.
    function automatic logic [4:0] hex_nibble(input logic [7:0] ch);
        logic [7:0] diff;
        diff = 8'h00;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            diff = ch - 8'h30;
            return {1'b1, diff[3:0]};
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            diff = ch - 8'h37;
            return {1'b1, diff[3:0]};
        end else if (ch >= 8'h61 && ch <= 8'h66) begin
            diff = ch - 8'h57;
            return {1'b1, diff[3:0]};
        end
        return 5'b0_0000;
    endfunction

endpackage

// File: rtl/uart_hex_line_rx_byte.sv
// 8N1 byte receiver: rx synchronizer, start/data/stop bit FSM and the
// mid-bit sampling down-counter.
module uart_byte_rx
    import uart_hex_pkg::*;
#(
    parameter int SAMPLECLOCK = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_strobe,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0]  ST_IDLE  = IDLE;
    localparam logic [1:0]  ST_START = START;
    localparam logic [1:0]  ST_DATA  = DATA;
    localparam logic [1:0]  ST_STOP  = STOP;
    localparam logic [15:0] RELOAD   = 16'(SAMPLECLOCK);
    localparam logic [15:0] HALF     = 16'(SAMPLECLOCK / 2);

    logic        rx_meta;
    logic        rx_s;
    logic        rx_d;
    logic [1:0]  state;
    logic [15:0] baudcnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_d        <= 1'b1;
            state       <= ST_IDLE;
            baudcnt     <= 16'd0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            rx_d        <= rx_s;
            byte_strobe <= 1'b0;
            frame_err   <= 1'b0;
            // Counter only runs while a frame is active; every action happens at zero.
            if (state != ST_IDLE && baudcnt != 16'd0) begin
                baudcnt <= baudcnt - 16'd1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_d && !rx_s) begin
                            baudcnt <= HALF;
                            state   <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (!rx_s) begin
                            baudcnt <= RELOAD;
                            bit_idx <= 3'd0;
                            state   <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {rx_s, shreg[7:1]};
                        baudcnt <= RELOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end
                    end
                    default: begin
                        byte_strobe <= rx_s;
                        frame_err   <= !rx_s;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data = shreg;
    assign busy = (state != ST_IDLE);

endmodule

// File: rtl/uart_hex_line_rx.sv
// Receives CR/LF-terminated ASCII hex lines over UART and presents the last
// completed line as a 32-bit value with a one-cycle strobe.
module uart_hex_line_rx
    import uart_hex_pkg::*;
#(
    parameter int BAUDRATE    = 115200,
    parameter int MASTERCLOCK = 50000000,
    parameter int SAMPLECLOCK = MASTERCLOCK / BAUDRATE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [31:0] value,
    output logic        value_good,
    output logic        error,
    output logic        busy
);

    logic [7:0]  data;
    logic        byte_strobe;
    logic        frame_err;
    logic [4:0]  nib;
    logic [31:0] acc;
    logic [3:0]  digits;
    logic        discard;

    uart_byte_rx #(
        .SAMPLECLOCK(SAMPLECLOCK)
    ) u_byte_rx (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .byte_strobe(byte_strobe),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    assign nib = hex_nibble(data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value      <= 32'd0;
            value_good <= 1'b0;
            error      <= 1'b0;
            acc        <= 32'd0;
            digits     <= 4'd0;
            discard    <= 1'b0;
        end else begin
            value_good <= 1'b0;
            error      <= 1'b0;
            if (frame_err) begin
                error   <= 1'b1;
                discard <= 1'b1;
            end else if (byte_strobe) begin
                if (nib[4]) begin
                    // Shifting drops the oldest nibble, so long lines keep the last 8 digits.
                    acc    <= {acc[27:0], nib[3:0]};
                    digits <= (digits == 4'd8) ? 4'd8 : digits + 4'd1;
                end else if (data == ASCII_CR || data == ASCII_LF) begin
                    if (digits != 4'd0 && !discard) begin
                        value      <= acc;
                        value_good <= 1'b1;
                    end
                    acc     <= 32'd0;
                    digits  <= 4'd0;
                    discard <= 1'b0;
                end else begin
                    error   <= 1'b1;
                    discard <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_hex_line_rx.md
# uart_hex_line_rx

UART receiver that accepts ASCII hexadecimal lines, for example "DEADBEEF" followed by CR/LF, and returns the assembled 32-bit value with a one-cycle strobe. It is the receive-side counterpart of the testbench/debug hex-print UART transmitter and uses the same 8N1 framing and baud-counter convention. It sits between an external `rx` pin and on-chip logic that consumes host-supplied words such as addresses, data patterns or commands.

## Interface
- `BAUDRATE`, 115200, line rate in bit/s.
- `MASTERCLOCK`, 50000000, `clk` frequency in Hz.
- `SAMPLECLOCK`, `MASTERCLOCK/BAUDRATE`, counter reload value. One bit lasts `SAMPLECLOCK+1` clocks. Must be at least 4 and below 65536.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `value`  out  32  last completed line value. Held until the next completion.
- `value_good`  out  1  one-cycle pulse when `value` is updated.
- `error`  out  1  one-cycle pulse on a framing error or an illegal character.
- `busy`  out  1  high while a frame is being received (any state other than IDLE).

## Operation
- `rx` passes through a 2-flop synchronizer to give `rx_s`, plus one more flop giving `rx_d` for edge detection.
- Bit FSM, with a 16-bit down-counter `baudcnt`:
  - IDLE: a falling edge (`rx_d`=1, `rx_s`=0) loads `baudcnt`=`SAMPLECLOCK/2` and moves to START.
  - START: at `baudcnt`==0, sample `rx_s`.
    - If 0: load `SAMPLECLOCK`, clear the bit index, go to DATA.
    - If 1 (glitch): return to IDLE silently.
  - DATA: at each `baudcnt`==0, shift `rx_s` into the byte LSB-first and reload `SAMPLECLOCK`. After the 8th bit, go to STOP.
  - STOP: at `baudcnt`==0, sample `rx_s`.
    - If 1: raise the internal `byte_strobe` with `byte`.
    - If 0: framing error.
    - Either way, return to IDLE. The next start requires a fresh falling edge, so a held-low break produces only one error.
- Line parser, acting on `byte_strobe` or a framing error:
  - '0'-'9', 'A'-'F', 'a'-'f': `acc <= {acc[27:0], nibble}`, `digits <= sat(digits+1, 8)`.
  - 0x0D or 0x0A: if `digits`>0 and `discard`==0, `value<=acc` and pulse `value_good`. Always clear `acc`, `digits` and `discard`.
  - Any other byte: pulse `error` and set `discard`. The rest of the line is ignored up to CR/LF.
  - Framing error: pulse `error`, set `discard`, do not parse the byte.
- More than 8 digits: only the last 8 are kept, with no error.
- An empty line, or CR followed by LF, produces no `value_good`.

## Timing
- Reset values:
  - `value`=0, `value_good`=0, `error`=0, `busy`=0.
  - FSM in IDLE, `acc`=0, `digits`=0, `discard`=0.
  - Synchronizer flops reset to 1.
- Sample points: mid-bit. The start bit is sampled `SAMPLECLOCK/2+1` clocks after the detected edge, and every later bit `SAMPLECLOCK+1` clocks after the previous sample.
- Latency: let E be the edge on which the stop bit is sampled.
  - `byte_strobe` is registered at E.
  - `value`, `value_good` and `error` are registered at E+1, one clock later.
  - From the physical falling edge of `rx`, synchronizer delay adds 3 clocks.
- `value_good` and `error` are never both high in the same cycle, and each is exactly one cycle wide.
- `busy` rises the cycle after the edge is detected and falls the cycle after E, or after a START glitch reject.
- Asserting `reset` mid-frame aborts immediately. After release, a frame already in progress on the line may be misdecoded. The parser recovers at the next CR/LF.
- Back-to-back frames with zero idle time are supported, because the stop-bit sample lands half a bit before the next start edge.

## Structure
- Package `uart_hex_pkg`:
  - `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A.
  - Bit-FSM state enum: IDLE, START, DATA, STOP.
  - Function `hex_nibble(byte) -> {valid, nibble[3:0]}`.
- Sub-module `uart_byte_rx`: synchronizer, bit FSM and counter. Outputs `byte[7:0]`, `byte_strobe`, `frame_err` and `busy`.
- Top level: instantiates `uart_byte_rx` and the line parser.

## Test plan
All scenarios use `MASTERCLOCK`=1000000, `BAUDRATE`=100000, so `SAMPLECLOCK`=10 and one bit is 11 clocks. A behavioural transmitter model drives `rx`.
- "DEADBEEF\r\n" back-to-back -> exactly one `value_good` with `value`=32'hDEADBEEF, one cycle after the CR stop sample, and `error` never high.
- "0000abcd\r" -> `value`=32'h0000ABCD. Then "5\n" -> `value`=32'h00000005.
- "12G4\r" -> one `error` pulse at 'G' and no `value_good` at CR. Then "7\r" -> `value`=32'h7.
- "123456789\r" -> `value`=32'h23456789 with no error. "\r\n" alone -> no pulse.
- Stop bit forced to 0 on 'A' of "A1\r" -> `error` pulse and no `value_good`. A 3-clock low glitch on idle `rx` -> no strobe, and `busy` drops within 7 clocks.
- `reset` asserted mid-data-bit of "FF" -> all outputs 0 immediately. After release, "\rCAFE\r" -> `value`=32'h0000CAFE.
